// File: rtl/ysyx_22050133_issue_ctrl.sv
// ysyx_22050133_issue_ctrl
//
// Issue and stall controller for the 5-stage RV64 pipeline. It sits beside
// the IDU and decides, every cycle, whether the instruction in ID may issue.
//   * A 32-entry pending-write scoreboard blocks RAW and WAW hazards.
//   * A two-state freeze FSM (RUN/FROZEN) holds the back-end while the
//     multi-cycle MUL/DIV unit or the AXI load/store unit is busy.
//   * EX-stage redirects flush IF/ID.
//   * A saturating counter records the number of cycles the PC was held.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   id_valid              ID holds a valid instruction
//   id_rs1/id_rs2/id_rd   ID register indices (0 when unused)
//   id_rdwen              ID instruction writes rd
//   wb_valid/wb_rdwen     WB stage valid / writes rd this cycle
//   wb_rd                 WB destination register
//   ex_mdu                EX holds a MUL/DIV/REM op (level)
//   mdu_done              one-cycle pulse, MDU result ready
//   lsu_req               MEM has an outstanding AXI access (level)
//   lsu_ack               one-cycle pulse, access complete
//   ex_redirect           EX resolved a control-flow change
//   has_hazard            bubble into ID/EX
//   pc_stall/ifid_stall   hold PC and IF/ID
//   ifid_flush            clear IF/ID valid
//   pipe_freeze           hold ID/EX, EX/MEM, MEM/WB
//   issue                 ID instruction accepted this cycle
//   stall_cnt             saturating count of pc_stall cycles
//   frozen                debug view of the freeze FSM (1 = FROZEN)
//
// Handshake: a producer's pulse (mdu_done, lsu_ack) is consumed in the cycle
// it is high; a unit is "waiting" while its level request is high and no
// completion has been seen. The back-end is frozen while any unit waits.

module ysyx_22050133_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rdwen,
    input  logic        wb_valid,
    input  logic        wb_rdwen,
    input  logic [4:0]  wb_rd,
    input  logic        ex_mdu,
    input  logic        mdu_done,
    input  logic        lsu_req,
    input  logic        lsu_ack,
    input  logic        ex_redirect,
    output logic        has_hazard,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        pipe_freeze,
    output logic        issue,
    output logic [31:0] stall_cnt,
    output logic        frozen
);

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pend;
    logic [31:0] pend_next;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        mdu_q;
    logic        lsu_q;
    logic        hz;
    logic        mdu_wait;
    logic        lsu_wait;
    logic [31:0] cnt_q;

    // pend[0] is never set, so x0 can never produce a hazard.
    assign hz = id_valid & (pend[id_rs1] | pend[id_rs2] | (id_rdwen & pend[id_rd]));

    assign stall_cnt = cnt_q;
    assign frozen    = (state == FROZEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        mdu_wait    = 1'b0;
        lsu_wait    = 1'b0;
        pipe_freeze = 1'b0;
        state_next  = RUN;
        has_hazard  = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        issue       = 1'b0;
        set_mask    = 32'd0;
        clr_mask    = 32'd0;
        pend_next   = pend;

        // A latched completion stands in for a pulse that arrived while the
        // other unit was still holding the freeze.
        mdu_wait    = ex_mdu  & ~mdu_done & ~mdu_q;
        lsu_wait    = lsu_req & ~lsu_ack  & ~lsu_q;
        pipe_freeze = mdu_wait | lsu_wait;
        state_next  = pipe_freeze ? FROZEN : RUN;

        // Priority: freeze > redirect > hazard. A redirect seen while frozen
        // is dropped; EX is held and will present it again.
        if (pipe_freeze) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            has_hazard = 1'b1;
        end else if (hz) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            has_hazard = 1'b1;
        end

        issue = id_valid & ~hz & ~ex_redirect & ~pipe_freeze;

        if (issue && id_rdwen && (id_rd != 5'd0)) begin
            set_mask = 32'd1 << id_rd;
        end
        if (wb_valid && wb_rdwen && (wb_rd != 5'd0)) begin
            clr_mask = 32'd1 << wb_rd;
        end

        // Set is applied after clear so a new writer wins over a retiring one.
        pend_next    = (pend & ~clr_mask) | set_mask;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= 32'd0;
            mdu_q <= 1'b0;
            lsu_q <= 1'b0;
            cnt_q <= 32'd0;
        end else begin
            pend <= pend_next;

            if (!pipe_freeze) begin
                mdu_q <= 1'b0;
                lsu_q <= 1'b0;
            end else begin
                if (mdu_done && lsu_wait) begin
                    mdu_q <= 1'b1;
                end
                if (lsu_ack && mdu_wait) begin
                    lsu_q <= 1'b1;
                end
            end

            if (pc_stall && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_issue_ctrl.sv
// Testbench for ysyx_22050133_issue_ctrl: directed scenarios with explicit
// expected values, then a randomized run checked against a behavioural model.

module tb_ysyx_22050133_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_rdwen;
    logic        wb_valid;
    logic        wb_rdwen;
    logic [4:0]  wb_rd;
    logic        ex_mdu;
    logic        mdu_done;
    logic        lsu_req;
    logic        lsu_ack;
    logic        ex_redirect;
    logic        has_hazard;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        pipe_freeze;
    logic        issue;
    logic [31:0] stall_cnt;
    logic        frozen;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22050133_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_rdwen    (id_rdwen),
        .wb_valid    (wb_valid),
        .wb_rdwen    (wb_rdwen),
        .wb_rd       (wb_rd),
        .ex_mdu      (ex_mdu),
        .mdu_done    (mdu_done),
        .lsu_req     (lsu_req),
        .lsu_ack     (lsu_ack),
        .ex_redirect (ex_redirect),
        .has_hazard  (has_hazard),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .pipe_freeze (pipe_freeze),
        .issue       (issue),
        .stall_cnt   (stall_cnt),
        .frozen      (frozen)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // busy_m[r]: a writer of r has issued and not yet retired.
    // seen flags: a unit's completion pulse already arrived during this freeze.
    bit          busy_m[32];
    bit          mdu_seen_m;
    bit          lsu_seen_m;
    bit          frozen_m;
    logic [31:0] cnt_m;
    bit e_hz, e_mw, e_lw, e_freeze, e_issue, e_has_hazard, e_pc_stall, e_flush;

    function automatic void model_comb();
        bit dep;
        dep = (id_rs1 != 0 && busy_m[id_rs1]) || (id_rs2 != 0 && busy_m[id_rs2]) ||
              (id_rdwen && id_rd != 0 && busy_m[id_rd]);
        e_hz     = id_valid && dep;
        e_mw     = ex_mdu && !mdu_done && !mdu_seen_m;
        e_lw     = lsu_req && !lsu_ack && !lsu_seen_m;
        e_freeze = e_mw || e_lw;
        e_issue  = id_valid && !e_hz && !ex_redirect && !e_freeze;
        if (e_freeze) begin
            e_pc_stall = 1; e_has_hazard = 0; e_flush = 0;
        end else if (ex_redirect) begin
            e_pc_stall = 0; e_has_hazard = 1; e_flush = 1;
        end else begin
            e_pc_stall = e_hz; e_has_hazard = e_hz; e_flush = 0;
        end
    endfunction

    function automatic void model_seq();
        model_comb();
        if (rst) begin
            foreach (busy_m[i]) busy_m[i] = 0;
            mdu_seen_m = 0;
            lsu_seen_m = 0;
            frozen_m   = 0;
            cnt_m      = 0;
        end else begin
            if (e_pc_stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
            if (wb_valid && wb_rdwen && wb_rd != 0) busy_m[wb_rd] = 0;
            if (e_issue && id_rdwen && id_rd != 0) busy_m[id_rd] = 1;
            frozen_m = e_freeze;
            if (!e_freeze) begin
                mdu_seen_m = 0;
                lsu_seen_m = 0;
            end else begin
                if (mdu_done && e_lw) mdu_seen_m = 1;
                if (lsu_ack && e_mw) lsu_seen_m = 1;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rdwen = 0;
        wb_valid = 0; wb_rdwen = 0; wb_rd = 0;
        ex_mdu = 0; mdu_done = 0; lsu_req = 0; lsu_ack = 0; ex_redirect = 0;
    endtask

    task automatic drive_id(input bit v, input int rs1, input int rs2, input int rd, input bit wen);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd); id_rdwen = wen;
    endtask

    task automatic drive_wb(input bit v, input int rd);
        wb_valid = v; wb_rdwen = v; wb_rd = 5'(rd);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        settle();
        n_vec++;
        if ({has_hazard, pc_stall, ifid_stall, ifid_flush, pipe_freeze, issue, frozen} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {has_hazard, pc_stall, ifid_stall, ifid_flush, pipe_freeze, issue, frozen});
        end
        n_vec++;
        if (stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt);
        end
        tick();
        rst = 0;
    endtask

    task automatic test_raw();
        do_reset();
        // x0 as destination must not create a pending entry
        drive_id(1, 0, 0, 0, 1);
        settle();
        tick();
        drive_id(1, 5, 0, 9, 0);
        settle();
        tick();
        drive_id(1, 0, 0, 0, 0);
        settle();
        n_vec++;
        if (issue !== 1'b1 || has_hazard !== 1'b0) begin
            n_err++; $display("FAIL x0_no_hazard: got issue=%b hz=%b want 1 0", issue, has_hazard);
        end
        tick();
        // addi x5 ; add x6,x5,x1
        drive_id(1, 0, 0, 5, 1);
        settle();
        n_vec++;
        if (issue !== 1'b1) begin
            n_err++; $display("FAIL raw_producer_issue: got %b want 1", issue);
        end
        tick();
        drive_id(1, 5, 1, 6, 1);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) drive_wb(1, 5); else drive_wb(0, 0);
            settle();
            n_vec++;
            if (has_hazard !== 1'b1 || issue !== 1'b0 || pc_stall !== 1'b1 || ifid_stall !== 1'b1) begin
                n_err++;
                $display("FAIL raw_stall_c%0d: got hz=%b iss=%b pcs=%b ifs=%b want 1 0 1 1",
                         c, has_hazard, issue, pc_stall, ifid_stall);
            end
            tick();
        end
        drive_wb(0, 0);
        settle();
        n_vec++;
        if (issue !== 1'b1 || has_hazard !== 1'b0 || pc_stall !== 1'b0) begin
            n_err++; $display("FAIL raw_consumer_issue: got iss=%b hz=%b pcs=%b want 1 0 0",
                              issue, has_hazard, pc_stall);
        end
        n_vec++;
        if (stall_cnt !== 32'd3) begin
            n_err++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_waw();
        do_reset();
        drive_id(1, 0, 0, 7, 1);
        settle();
        tick();
        drive_id(1, 2, 3, 7, 1);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) drive_wb(1, 7); else drive_wb(0, 0);
            settle();
            n_vec++;
            if (has_hazard !== 1'b1 || issue !== 1'b0) begin
                n_err++; $display("FAIL waw_stall_c%0d: got hz=%b iss=%b want 1 0", c, has_hazard, issue);
            end
            tick();
        end
        drive_wb(0, 0);
        settle();
        n_vec++;
        if (issue !== 1'b1) begin
            n_err++; $display("FAIL waw_second_issue: got %b want 1", issue);
        end
        tick();
        // second writer now owns x7: reader must still wait
        drive_id(1, 7, 0, 0, 0);
        settle();
        n_vec++;
        if (has_hazard !== 1'b1) begin
            n_err++; $display("FAIL waw_pend_kept: got %b want 1", has_hazard);
        end
        tick();
        // same-cycle set and clear on x8: set wins
        drive_id(1, 0, 0, 8, 1);
        drive_wb(1, 8);
        settle();
        tick();
        drive_wb(0, 0);
        drive_id(1, 8, 0, 0, 0);
        settle();
        n_vec++;
        if (has_hazard !== 1'b1 || issue !== 1'b0) begin
            n_err++; $display("FAIL set_beats_clear: got hz=%b iss=%b want 1 0", has_hazard, issue);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mdu();
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            ex_mdu = 1;
            mdu_done = (c == 10);
            settle();
            n_vec++;
            if (pipe_freeze !== (c != 10) || pc_stall !== (c != 10)) begin
                n_err++; $display("FAIL mdu_freeze_c%0d: got frz=%b pcs=%b want %b", c, pipe_freeze, pc_stall, c != 10);
            end
            if (c == 2) begin
                n_vec++;
                if (frozen !== 1'b1) begin
                    n_err++; $display("FAIL mdu_state_frozen: got %b want 1", frozen);
                end
            end
            tick();
        end
        idle_inputs();
        settle();
        n_vec++;
        if (stall_cnt !== 32'd9 || frozen !== 1'b0) begin
            n_err++; $display("FAIL mdu_stall_cnt: got cnt=%0d st=%b want 9 0", stall_cnt, frozen);
        end
        // zero-wait LSU
        lsu_req = 1; lsu_ack = 1;
        settle();
        n_vec++;
        if (pipe_freeze !== 1'b0) begin
            n_err++; $display("FAIL lsu_zero_wait: got %b want 0", pipe_freeze);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mdu_lsu();
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            ex_mdu   = (c <= 6);
            mdu_done = (c == 6);
            lsu_req  = 1;
            lsu_ack  = (c == 3) || (c == 8);
            settle();
            // cycle 7 is a fresh LSU access: freezes only if lsu_q was cleared
            n_vec++;
            if (pipe_freeze !== (c != 6 && c != 8)) begin
                n_err++; $display("FAIL mdu_lsu_c%0d: got %b want %b", c, pipe_freeze, (c != 6 && c != 8));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        drive_id(1, 0, 0, 5, 1);
        settle();
        tick();
        drive_id(1, 5, 0, 9, 1);
        ex_redirect = 1;
        settle();
        n_vec++;
        if ({ifid_flush, has_hazard, issue, pc_stall, ifid_stall} !== 5'b11000) begin
            n_err++; $display("FAIL redirect_outputs: got %b want 11000",
                              {ifid_flush, has_hazard, issue, pc_stall, ifid_stall});
        end
        tick();
        // pend[5] kept, pend[9] not set by the flushed instruction
        ex_redirect = 0;
        drive_id(1, 5, 0, 0, 0);
        settle();
        n_vec++;
        if (has_hazard !== 1'b1) begin
            n_err++; $display("FAIL redirect_pend_kept: got %b want 1", has_hazard);
        end
        tick();
        drive_id(1, 9, 0, 0, 0);
        settle();
        n_vec++;
        if (has_hazard !== 1'b0 || issue !== 1'b1) begin
            n_err++; $display("FAIL redirect_no_set: got hz=%b iss=%b want 0 1", has_hazard, issue);
        end
        tick();
        // redirect during a freeze is held off
        drive_id(0, 0, 0, 0, 0);
        ex_redirect = 1; ex_mdu = 1;
        settle();
        n_vec++;
        if ({ifid_flush, has_hazard, pc_stall} !== 3'b001) begin
            n_err++; $display("FAIL redirect_frozen: got %b want 001", {ifid_flush, has_hazard, pc_stall});
        end
        tick();
        mdu_done = 1;
        settle();
        n_vec++;
        if ({ifid_flush, has_hazard, pc_stall} !== 3'b110) begin
            n_err++; $display("FAIL redirect_after_freeze: got %b want 110", {ifid_flush, has_hazard, pc_stall});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_saturate();
        do_reset();
        drive_id(1, 0, 0, 5, 1);
        settle();
        tick();
        drive_id(1, 0, 0, 7, 1);
        settle();
        tick();
        drive_id(0, 0, 0, 0, 0);
        ex_mdu = 1;
        settle();
        tick();
        tick();
        // reset mid-freeze with x5 and x7 pending
        rst = 1; ex_mdu = 0;
        settle();
        tick();
        rst = 0;
        drive_id(1, 5, 7, 0, 0);
        settle();
        n_vec++;
        if (has_hazard !== 1'b0 || pipe_freeze !== 1'b0 || stall_cnt !== 32'd0 || frozen !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_freeze: got hz=%b frz=%b cnt=%0d st=%b want 0 0 0 0",
                              has_hazard, pipe_freeze, stall_cnt, frozen);
        end
        tick();
        drive_id(1, 0, 0, 5, 1);
        settle();
        tick();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        cnt_m = 32'hFFFF_FFFF;
        drive_id(1, 5, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if (stall_cnt !== 32'hFFFF_FFFF || pc_stall !== 1'b1) begin
                n_err++; $display("FAIL stall_cnt_saturate_%0d: got cnt=%h pcs=%b want ffffffff 1", c, stall_cnt, pc_stall);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int busy_list[$];
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd  = 5'($urandom_range(0, 7));
            id_rdwen = $urandom_range(0, 1);
            busy_list.delete();
            foreach (busy_m[i]) if (busy_m[i]) busy_list.push_back(i);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_rdwen = ($urandom_range(0, 9) != 0);
            if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
                wb_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                wb_rd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ex_mdu = ~ex_mdu;
            if ($urandom_range(0, 9) == 0) lsu_req = ~lsu_req;
            mdu_done = ($urandom_range(0, 5) == 0);
            lsu_ack  = ($urandom_range(0, 5) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            settle();
            n_vec++;
            if ({has_hazard, pc_stall, ifid_stall, ifid_flush, pipe_freeze, issue} !==
                {e_has_hazard, e_pc_stall, e_pc_stall, e_flush, e_freeze, e_issue}) begin
                n_err++;
                $display("FAIL rand_ctrl_%0d: got %b want %b", c,
                         {has_hazard, pc_stall, ifid_stall, ifid_flush, pipe_freeze, issue},
                         {e_has_hazard, e_pc_stall, e_pc_stall, e_flush, e_freeze, e_issue});
            end
            n_vec++;
            if (stall_cnt !== cnt_m || frozen !== frozen_m) begin
                n_err++; $display("FAIL rand_state_%0d: got cnt=%0d st=%b want %0d %b",
                                  c, stall_cnt, frozen, cnt_m, frozen_m);
            end
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_raw();
        test_waw();
        test_mdu();
        test_mdu_lsu();
        test_redirect();
        test_reset_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
